pipe_chain: RTL and testbench

PIPE_CHAIN -- requirements
Module: pipe_chain

---
 rtl/pipe_chain_pkg.sv | 15 +
 rtl/pipe_chain_if.sv | 28 ++
 rtl/pipe_stage_reg.sv | 32 +++
 rtl/pipe_chain.sv | 61 ++++++
 tb/tb_pipe_chain.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/pipe_chain_pkg.sv
// pipe_chain_pkg: shared pipeline limits, default payload width and the
// occupancy counting helper used by the chain.
package pipe_chain_pkg;
    localparam int WIDTH_DEF  = 32;
    localparam int STAGES_DEF = 4;
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 8;

    function automatic logic [3:0] count_valid(input logic [STAGES_MAX-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < STAGES_MAX; i++) c += {3'b0, v[i]};
        return c;
    endfunction
endpackage

// File: rtl/pipe_chain_if.sv
// pipe_chain_if: payload, stall/kill controls and status taps of the chain.
interface pipe_chain_if
    import pipe_chain_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int STAGES = STAGES_DEF
);
    logic                     in_valid;
    logic [WIDTH-1:0]         in_data;
    logic                     in_ready;
    logic [STAGES-1:0]        freeze;
    logic [STAGES-1:0]        flush;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic [STAGES-1:0]        stage_valid;
    logic [WIDTH*STAGES-1:0]  stage_data;
    logic [3:0]               occupancy;
    logic [15:0]              bubble_cnt;

    modport master (
        output in_valid, in_data, freeze, flush,
        input  in_ready, out_valid, out_data, stage_valid, stage_data, occupancy, bubble_cnt
    );
    modport slave (
        input  in_valid, in_data, freeze, flush,
        output in_ready, out_valid, out_data, stage_valid, stage_data, occupancy, bubble_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one valid+data stage; flush beats hold, hold beats load,
// and a held upstream stage feeds a bubble instead of its contents.
module pipe_stage_reg #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             hold_i,
    input  logic             up_hold_i,
    input  logic             up_valid_i,
    input  logic [WIDTH-1:0] up_data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = flush_i ? 1'b0 : hold_i ? valid_q : up_valid_i & ~up_hold_i;
        data_d  = flush_i ? RST_VAL : hold_i ? data_q : up_hold_i ? RST_VAL : up_data_i;
    end

    always_ff @(posedge clk) begin
        valid_q <= rst ? 1'b0 : valid_d;
        data_q  <= rst ? RST_VAL : data_d;
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/pipe_chain.sv
// pipe_chain: STAGES-deep register pipeline with per-stage freeze/flush,
// occupancy tap and a saturating output-bubble counter.
module pipe_chain
    import pipe_chain_pkg::*;
#(
    parameter int               WIDTH   = WIDTH_DEF,
    parameter int               STAGES  = STAGES_DEF,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input logic         clk,
    input logic         rst,
    pipe_chain_if.slave bus
);
    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("pipe_chain: STAGES out of range");
    end

    logic [STAGES-1:0]       hold;
    logic [STAGES-1:0]       stage_valid;
    logic [WIDTH*STAGES-1:0] stage_data;
    logic [15:0]             bubble_q, bubble_d;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             up_hold, up_valid;
        logic [WIDTH-1:0] up_data;
        // a stall anywhere downstream freezes this stage too
        assign hold[k] = |(bus.freeze >> k);
        if (k == 0) begin : g_head
            assign up_hold  = 1'b0;
            assign up_valid = bus.in_valid;
            assign up_data  = bus.in_data;
        end else begin : g_body
            assign up_hold  = hold[k-1];
            assign up_valid = stage_valid[k-1];
            assign up_data  = stage_data[(k-1)*WIDTH +: WIDTH];
        end
        pipe_stage_reg #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_reg (
            .clk        (clk),
            .rst        (rst),
            .flush_i    (bus.flush[k]),
            .hold_i     (hold[k]),
            .up_hold_i  (up_hold),
            .up_valid_i (up_valid),
            .up_data_i  (up_data),
            .valid_o    (stage_valid[k]),
            .data_o     (stage_data[k*WIDTH +: WIDTH])
        );
    end

    always_comb bubble_d = (!stage_valid[STAGES-1] && bubble_q != 16'hFFFF) ? bubble_q + 16'd1 : bubble_q;

    always_ff @(posedge clk) bubble_q <= rst ? '0 : bubble_d;

    assign bus.in_ready    = ~hold[0];
    assign bus.out_valid   = stage_valid[STAGES-1];
    assign bus.out_data    = stage_data[(STAGES-1)*WIDTH +: WIDTH];
    assign bus.stage_valid = stage_valid;
    assign bus.stage_data  = stage_data;
    assign bus.occupancy   = count_valid(STAGES_MAX'(stage_valid));
    assign bus.bubble_cnt  = bubble_q;
endmodule

// File: tb/tb_pipe_chain.sv
// tb_pipe_chain: scoreboard bench for pipe_chain at WIDTH=32, STAGES=4.
module tb_pipe_chain;
    localparam int W = 32;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] sdat[S];

    pipe_chain_if #(.WIDTH(W), .STAGES(S)) vif();
    pipe_chain #(.WIDTH(W), .STAGES(S), .RST_VAL('0)) dut (.clk(clk), .rst(rst), .bus(vif.slave));

    always #5 clk = ~clk;

    for (genvar k = 0; k < S; k++) begin : g_tap
        assign sdat[k] = vif.stage_data[k*W +: W];
    end

    task automatic step();
        logic acc;
        logic [W-1:0] d, e;
        #1;
        n_vec++;
        if (vif.in_ready !== !(|vif.freeze)) begin
            n_err++; $display("FAIL in_ready got=%b exp=%b", vif.in_ready, !(|vif.freeze));
        end
        acc = vif.in_valid && !(|vif.freeze);
        d = vif.in_data;
        @(posedge clk); #1;
        if (rst) exp_q.delete();
        else if (acc) begin
            exp_q.push_back(d);
            vif.in_data = d + 4;
        end
        if (vif.out_valid === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++; $display("FAIL sb_extra out_data=%h exp=none", vif.out_data);
            end else begin
                e = exp_q.pop_front();
                if (vif.out_data !== e) begin
                    n_err++; $display("FAIL sb_order out_data=%h exp=%h", vif.out_data, e);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1; vif.in_valid = 1; vif.in_data = 32'hDEAD_BEEF; vif.freeze = 4'b1010; vif.flush = 4'b0101;
        step();
        rst = 0; vif.in_valid = 0; vif.in_data = '0; vif.freeze = '0; vif.flush = '0;
        #1;
        n_vec++; if (vif.stage_valid !== 4'b0000) begin n_err++; $display("FAIL rst_valid got=%b exp=0000", vif.stage_valid); end
        n_vec++; if (vif.stage_data !== '0) begin n_err++; $display("FAIL rst_data got=%h exp=0", vif.stage_data); end
        n_vec++; if (vif.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b exp=0", vif.out_valid); end
        n_vec++; if (vif.occupancy !== 4'd0) begin n_err++; $display("FAIL rst_occ got=%0d exp=0", vif.occupancy); end
        n_vec++; if (vif.bubble_cnt !== 16'd0) begin n_err++; $display("FAIL rst_bubble got=%0d exp=0", vif.bubble_cnt); end
        n_vec++; if (vif.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got=%b exp=1", vif.in_ready); end
    endtask

    task automatic test_stream();
        vif.in_valid = 1; vif.in_data = '0;
        for (int i = 1; i <= 4; i++) begin
            step();
            n_vec++;
            if (vif.out_valid !== (i == 4)) begin n_err++; $display("FAIL stream_lat edge=%0d got=%b exp=%b", i, vif.out_valid, i == 4); end
        end
        n_vec++; if (vif.out_data !== 32'h0) begin n_err++; $display("FAIL stream_first got=%h exp=0", vif.out_data); end
        n_vec++; if (vif.occupancy !== 4'd4) begin n_err++; $display("FAIL stream_occ got=%0d exp=4", vif.occupancy); end
        n_vec++; if (vif.bubble_cnt !== 16'd4) begin n_err++; $display("FAIL stream_bubble got=%0d exp=4", vif.bubble_cnt); end
        repeat (3) step();
        n_vec++; if (vif.out_data !== 32'hC) begin n_err++; $display("FAIL stream_step got=%h exp=c", vif.out_data); end
        n_vec++; if (vif.bubble_cnt !== 16'd4) begin n_err++; $display("FAIL stream_bubble_hold got=%0d exp=4", vif.bubble_cnt); end
    endtask

    task automatic test_freeze();
        logic [W-1:0] nd;
        nd = vif.in_data;
        vif.freeze = 4'b0100;
        for (int i = 0; i < 2; i++) begin
            step();
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (sdat[k] !== nd - W'(4 * (k + 1)) || vif.stage_valid[k] !== 1'b1) begin
                    n_err++; $display("FAIL freeze_hold stage=%0d got=%h/%b exp=%h/1", k, sdat[k], vif.stage_valid[k], nd - W'(4 * (k + 1)));
                end
            end
            n_vec++; if (vif.out_valid !== 1'b0) begin n_err++; $display("FAIL freeze_bubble got=%b exp=0", vif.out_valid); end
        end
        n_vec++; if (vif.bubble_cnt !== 16'd5) begin n_err++; $display("FAIL freeze_bcnt got=%0d exp=5", vif.bubble_cnt); end
        vif.freeze = '0;
        step();
        n_vec++; if (vif.out_valid !== 1'b1) begin n_err++; $display("FAIL freeze_resume got=%b exp=1", vif.out_valid); end
        n_vec++; if (vif.bubble_cnt !== 16'd6) begin n_err++; $display("FAIL freeze_bcnt2 got=%0d exp=6", vif.bubble_cnt); end
        repeat (3) step();
    endtask

    task automatic test_freeze_flush();
        rst = 1; vif.in_valid = 0;
        step();
        rst = 0; vif.in_valid = 1; vif.in_data = '0;
        repeat (4) step();
        vif.freeze = 4'b0010; vif.flush = 4'b0010;
        exp_q.delete(1);
        step();
        n_vec++; if (vif.stage_valid[1] !== 1'b0 || sdat[1] !== '0) begin n_err++; $display("FAIL ff_kill got=%b/%h exp=0/0", vif.stage_valid[1], sdat[1]); end
        n_vec++; if (vif.stage_valid[0] !== 1'b1 || sdat[0] !== 32'hC) begin n_err++; $display("FAIL ff_keep got=%b/%h exp=1/c", vif.stage_valid[0], sdat[0]); end
        n_vec++; if (vif.in_ready !== 1'b0) begin n_err++; $display("FAIL ff_ready got=%b exp=0", vif.in_ready); end
        n_vec++; if (vif.occupancy !== 4'd2) begin n_err++; $display("FAIL ff_occ got=%0d exp=2", vif.occupancy); end
        vif.freeze = '0; vif.flush = '0;
        repeat (6) step();
        vif.in_valid = 0;
        repeat (4) step();
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL ff_drain left=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_reset_midstream();
        vif.in_valid = 1;
        repeat (5) step();
        rst = 1;
        step();
        rst = 0; vif.in_valid = 0;
        #1;
        n_vec++; if (vif.stage_valid !== 4'b0000) begin n_err++; $display("FAIL mid_valid got=%b exp=0000", vif.stage_valid); end
        n_vec++; if (vif.out_data !== '0) begin n_err++; $display("FAIL mid_data got=%h exp=0", vif.out_data); end
        n_vec++; if (vif.bubble_cnt !== 16'd0) begin n_err++; $display("FAIL mid_bubble got=%0d exp=0", vif.bubble_cnt); end
        vif.in_valid = 1; vif.in_data = 32'h1234;
        step();
        vif.in_valid = 0;
        for (int i = 2; i <= 4; i++) begin
            step();
            n_vec++;
            if (vif.out_valid !== (i == 4)) begin n_err++; $display("FAIL mid_lat edge=%0d got=%b exp=%b", i, vif.out_valid, i == 4); end
        end
        n_vec++; if (vif.out_data !== 32'h1234) begin n_err++; $display("FAIL mid_entry got=%h exp=1234", vif.out_data); end
        n_vec++; if (vif.bubble_cnt !== 16'd4) begin n_err++; $display("FAIL mid_bcnt got=%0d exp=4", vif.bubble_cnt); end
    endtask

    task automatic test_bubble_sat();
        rst = 1; vif.in_valid = 0;
        step();
        rst = 0;
        repeat (100) step();
        n_vec++; if (vif.bubble_cnt !== 16'd100) begin n_err++; $display("FAIL sat_count got=%0d exp=100", vif.bubble_cnt); end
        repeat (69900) step();
        n_vec++; if (vif.bubble_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_max got=%h exp=ffff", vif.bubble_cnt); end
        repeat (2) step();
        n_vec++; if (vif.bubble_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_stay got=%h exp=ffff", vif.bubble_cnt); end
        vif.in_valid = 1; vif.in_data = 32'hABCD;
        step();
        vif.in_valid = 0;
        repeat (5) step();
        n_vec++; if (vif.bubble_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_valid got=%h exp=ffff", vif.bubble_cnt); end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sat_drain left=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_freeze();
        test_freeze_flush();
        test_reset_midstream();
        test_bubble_sat();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
